ldm_ctrl: RTL and testbench

Sequencer for block data transfer instructions (LDM/STM) in the ARMv4 core. It accepts one decoded LDM/STM and issues one word transfer per cycle to the EX stage: base-relative offset, memory-valid flag and target register code. For stores it also supplies the register read-port code and forwards the read data as store data. It stalls the upstream pipeline until the list is exhausted, then issues the optional base writeback.

---
 rtl/ldm_ctrl_pkg.sv | 42 ++++
 rtl/ldm_ctrl_lsb_enc16.sv | 32 +++
 rtl/ldm_ctrl.sv | 158 +++++++++++++++
 tb/tb_ldm_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldm_ctrl_pkg.sv
// Shared types and helpers for the LDM/STM block-transfer sequencer.
// Offsets are byte offsets relative to the base register Rn.
package ldm_ctrl_pkg;

    typedef enum logic [1:0] {
        LDM_IDLE = 2'd0,
        LDM_XFER = 2'd1,
        LDM_BASE = 2'd2
    } ldm_state_e;

    // Instruction fields captured at start and held for the whole sequence.
    typedef struct packed {
        logic       load;
        logic       up;
        logic       wb;
        logic [3:0] base;
    } ldm_instr_t;

    localparam logic [31:0] WORD_BYTES = 32'd4;

    function automatic logic [31:0] words_to_bytes(input logic [4:0] n);
        return {25'd0, n, 2'b00};
    endfunction

    // Offset of the lowest-numbered register; the remaining registers
    // always follow at increasing addresses, whatever the direction.
    function automatic logic [31:0] start_offset(input logic       pre,
                                                 input logic       up,
                                                 input logic [4:0] n);
        logic [31:0] four_n;
        logic [31:0] off;
        four_n = words_to_bytes(n);
        case ({pre, up})
            2'b01:   off = 32'd0;                    // IA
            2'b11:   off = WORD_BYTES;               // IB
            2'b00:   off = WORD_BYTES - four_n;      // DA
            default: off = 32'd0 - four_n;           // DB
        endcase
        return off;
    endfunction

endpackage

// File: rtl/ldm_ctrl_lsb_enc16.sv
// Lowest-set-bit encoder: index of the lowest 1 in a 16-bit vector,
// plus a flag telling whether any bit is set at all.
module lsb_enc16 (
    input  logic [15:0] vec_i,
    output logic [3:0]  idx_o,
    output logic        vld_o
);

    logic [15:0] first;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_first
            if (gi == 0) begin : g_lsb
                assign first[gi] = vec_i[gi];
            end else begin : g_upper
                assign first[gi] = vec_i[gi] & ~(|vec_i[gi-1:0]);
            end
        end
    endgenerate

    // first is one-hot (or zero), so OR-ing the indices is exact.
    always_comb begin
        idx_o = 4'd0;
        for (int i = 0; i < 16; i++) begin
            idx_o = idx_o | ({4{first[i]}} & 4'(i));
        end
    end

    assign vld_o = |vec_i;

endmodule

// File: rtl/ldm_ctrl.sv
// LDM/STM sequencer: walks the register list lowest-first, one word per
// accepted memory cycle, then optionally issues the base writeback.
module ldm_ctrl
    import ldm_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [15:0] i_reg_list,
    input  logic        i_load,
    input  logic        i_pre,
    input  logic        i_up,
    input  logic        i_wb,
    input  logic [3:0]  i_base_code,
    input  logic        i_mem_ready,
    input  logic [31:0] i_rf_rd_data,
    output logic        o_stall,
    output logic        o_ldm_vld,
    output logic [31:0] o_ldm_offset,
    output logic        o_ldm_mem_vld,
    output logic [3:0]  o_ldm_reg_code,
    output logic [31:0] o_ldm_reg,
    output logic [3:0]  o_rf_rd_code,
    output logic        o_base_wb_vld,
    output logic [31:0] o_base_wb_offset,
    output logic        o_pc_loaded,
    output logic        o_done
);

    ldm_state_e  state_q,      state_d;
    logic [15:0] mask_q,       mask_d;
    logic [4:0]  cnt_q,        cnt_d;
    logic [4:0]  n_q,          n_d;
    logic [31:0] start_off_q,  start_off_d;
    ldm_instr_t  instr_q,      instr_d;
    logic        empty_done_q, empty_done_d;

    logic [4:0]  list_pop;
    logic [3:0]  lsb_idx;
    logic        lsb_vld;
    logic        in_xfer;
    logic        in_base;
    logic        last_xfer;
    logic        xfer_adv;
    logic [3:0]  reg_code;

    always_comb begin
        list_pop = 5'd0;
        for (int i = 0; i < 16; i++) begin
            list_pop = list_pop + {4'd0, i_reg_list[i]};
        end
    end

    lsb_enc16 u_lsb_enc (
        .vec_i (mask_q),
        .idx_o (lsb_idx),
        .vld_o (lsb_vld)
    );

    assign in_xfer   = (state_q == LDM_XFER);
    assign in_base   = (state_q == LDM_BASE);
    // At most one bit left in the mask means this is the final transfer.
    assign last_xfer = ((mask_q & (mask_q - 16'd1)) == 16'd0);
    assign xfer_adv  = in_xfer & i_mem_ready;

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        cnt_d        = cnt_q;
        n_d          = n_q;
        start_off_d  = start_off_q;
        instr_d      = instr_q;
        empty_done_d = 1'b0;

        case (state_q)
            LDM_IDLE: begin
                if (i_start) begin
                    mask_d        = i_reg_list;
                    n_d           = list_pop;
                    cnt_d         = 5'd0;
                    start_off_d   = start_offset(i_pre, i_up, list_pop);
                    instr_d.load  = i_load;
                    instr_d.up    = i_up;
                    instr_d.wb    = i_wb;
                    instr_d.base  = i_base_code;
                    if (list_pop != 5'd0) begin
                        state_d = LDM_XFER;
                    end else if (i_wb) begin
                        state_d = LDM_BASE;
                    end else begin
                        empty_done_d = 1'b1;
                    end
                end
            end
            LDM_XFER: begin
                if (i_mem_ready) begin
                    mask_d = mask_q & (mask_q - 16'd1);
                    cnt_d  = cnt_q + 5'd1;
                    if (last_xfer) begin
                        state_d = instr_q.wb ? LDM_BASE : LDM_IDLE;
                    end
                end
            end
            LDM_BASE: begin
                state_d = LDM_IDLE;
            end
            default: begin
                state_d = LDM_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= LDM_IDLE;
            mask_q       <= 16'd0;
            cnt_q        <= 5'd0;
            n_q          <= 5'd0;
            start_off_q  <= 32'd0;
            instr_q      <= '0;
            empty_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            cnt_q        <= cnt_d;
            n_q          <= n_d;
            start_off_q  <= start_off_d;
            instr_q      <= instr_d;
            empty_done_q <= empty_done_d;
        end
    end

    always_comb begin
        reg_code = 4'd0;
        if (in_xfer) begin
            reg_code = lsb_idx;
        end else if (in_base) begin
            reg_code = instr_q.base;
        end
    end

    assign o_stall          = (state_q != LDM_IDLE);
    assign o_ldm_vld        = in_xfer | in_base;
    assign o_ldm_mem_vld    = in_xfer & lsb_vld;
    assign o_ldm_offset     = in_xfer ? (start_off_q + words_to_bytes(cnt_q)) : 32'd0;
    assign o_ldm_reg_code   = reg_code;
    assign o_rf_rd_code     = reg_code;
    assign o_ldm_reg        = i_rf_rd_data;
    assign o_base_wb_vld    = in_base;
    assign o_base_wb_offset = in_base ? (instr_q.up ? words_to_bytes(n_q)
                                                    : 32'd0 - words_to_bytes(n_q))
                                      : 32'd0;
    assign o_pc_loaded      = xfer_adv & instr_q.load & (lsb_idx == 4'd15);
    // Retire on the last accepted transfer, on the writeback cycle, or one
    // cycle after an empty list without writeback.
    assign o_done           = empty_done_q | in_base | (xfer_adv & last_xfer & ~instr_q.wb);

endmodule

// File: tb/tb_ldm_ctrl.sv
// Directed, table-driven bench for ldm_ctrl: one row per clock cycle with
// hand-computed expected outputs, plus a hand-written reset-abort sequence.
module tb_ldm_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [15:0] i_reg_list;
    logic        i_load;
    logic        i_pre;
    logic        i_up;
    logic        i_wb;
    logic [3:0]  i_base_code;
    logic        i_mem_ready;
    logic [31:0] i_rf_rd_data;
    logic        o_stall;
    logic        o_ldm_vld;
    logic [31:0] o_ldm_offset;
    logic        o_ldm_mem_vld;
    logic [3:0]  o_ldm_reg_code;
    logic [31:0] o_ldm_reg;
    logic [3:0]  o_rf_rd_code;
    logic        o_base_wb_vld;
    logic [31:0] o_base_wb_offset;
    logic        o_pc_loaded;
    logic        o_done;

    always #5 i_clk = ~i_clk;

    ldm_ctrl dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_start          (i_start),
        .i_reg_list       (i_reg_list),
        .i_load           (i_load),
        .i_pre            (i_pre),
        .i_up             (i_up),
        .i_wb             (i_wb),
        .i_base_code      (i_base_code),
        .i_mem_ready      (i_mem_ready),
        .i_rf_rd_data     (i_rf_rd_data),
        .o_stall          (o_stall),
        .o_ldm_vld        (o_ldm_vld),
        .o_ldm_offset     (o_ldm_offset),
        .o_ldm_mem_vld    (o_ldm_mem_vld),
        .o_ldm_reg_code   (o_ldm_reg_code),
        .o_ldm_reg        (o_ldm_reg),
        .o_rf_rd_code     (o_rf_rd_code),
        .o_base_wb_vld    (o_base_wb_vld),
        .o_base_wb_offset (o_base_wb_offset),
        .o_pc_loaded      (o_pc_loaded),
        .o_done           (o_done)
    );

    typedef struct {
        logic        rst;
        logic        start;
        logic [15:0] list;
        logic        load;
        logic        pre;
        logic        up;
        logic        wb;
        logic [3:0]  base;
        logic        ready;
        logic        chk;
        logic        stall;
        logic        vld;
        logic [31:0] off;
        logic        memv;
        logic [3:0]  code;
        logic        wbv;
        logic [31:0] wboff;
        logic        pcl;
        logic        done;
    } row_t;

    row_t rows[$];

    logic        c_rst, c_start, c_load, c_pre, c_up, c_wb, c_ready;
    logic [15:0] c_list;
    logic [3:0]  c_base;

    int n_chk   = 0;
    int n_fail  = 0;
    int cur_row = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, cur_row, act, exp);
        end
    endtask

    task automatic push(input logic chk_en, input logic stall, input logic vld,
                        input logic [31:0] off, input logic memv, input logic [3:0] code,
                        input logic wbv, input logic [31:0] wboff, input logic pcl,
                        input logic done);
        row_t r;
        r.rst   = c_rst;   r.start = c_start; r.list = c_list;  r.load = c_load;
        r.pre   = c_pre;   r.up    = c_up;    r.wb   = c_wb;    r.base = c_base;
        r.ready = c_ready; r.chk   = chk_en;  r.stall = stall;  r.vld  = vld;
        r.off   = off;     r.memv  = memv;    r.code = code;    r.wbv  = wbv;
        r.wboff = wboff;   r.pcl   = pcl;     r.done = done;
        rows.push_back(r);
    endtask

    task automatic idle_row(input logic done);
        push(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0, done);
    endtask

    task automatic xfer_row(input logic [3:0] code, input logic [31:0] off,
                            input logic pcl, input logic done);
        push(1'b1, 1'b1, 1'b1, off, 1'b1, code, 1'b0, 32'd0, pcl, done);
    endtask

    task automatic base_row(input logic [3:0] code, input logic [31:0] wboff);
        push(1'b1, 1'b1, 1'b1, 32'd0, 1'b0, code, 1'b1, wboff, 1'b0, 1'b1);
    endtask

    // Start row in IDLE, then scramble the captured fields so that any
    // later dependence on live inputs shows up as a mismatch.
    task automatic issue(input logic [15:0] list, input logic load, input logic pre,
                         input logic up, input logic wb, input logic [3:0] base);
        c_start = 1'b1; c_list = list; c_load = load; c_pre = pre;
        c_up = up; c_wb = wb; c_base = base;
        idle_row(1'b0);
        c_start = 1'b0; c_list = ~list; c_load = ~load; c_pre = ~pre;
        c_up = ~up; c_wb = ~wb; c_base = ~base;
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic apply_row(input row_t r);
        logic [31:0] rd;
        rd = $urandom;
        i_rst = r.rst; i_start = r.start; i_reg_list = r.list; i_load = r.load;
        i_pre = r.pre; i_up = r.up; i_wb = r.wb; i_base_code = r.base;
        i_mem_ready = r.ready; i_rf_rd_data = rd;
        #2;
        if (r.chk) begin
            chk("stall",     32'(o_stall),          32'(r.stall));
            chk("ldm_vld",   32'(o_ldm_vld),        32'(r.vld));
            chk("offset",    o_ldm_offset,          r.off);
            chk("mem_vld",   32'(o_ldm_mem_vld),    32'(r.memv));
            chk("reg_code",  32'(o_ldm_reg_code),   32'(r.code));
            chk("rf_rd",     32'(o_rf_rd_code),     32'(r.code));
            chk("ldm_reg",   o_ldm_reg,             rd);
            chk("wb_vld",    32'(o_base_wb_vld),    32'(r.wbv));
            chk("wb_offset", o_base_wb_offset,      r.wboff);
            chk("pc_loaded", 32'(o_pc_loaded),      32'(r.pcl));
            chk("done",      32'(o_done),           32'(r.done));
        end
        step();
    endtask

    initial begin
        c_rst = 1'b1; c_start = 1'b0; c_list = 16'd0; c_load = 1'b0; c_pre = 1'b0;
        c_up = 1'b0; c_wb = 1'b0; c_base = 4'd0; c_ready = 1'b1;

        // Reset: first row settles the registers, second checks them.
        push(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        idle_row(1'b0);
        c_rst = 1'b0;

        // LDMIA {1,2,5}, no writeback; a stray start mid-sequence is ignored.
        issue(16'h0026, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3);
        xfer_row(4'd1, 32'd0, 1'b0, 1'b0);
        c_start = 1'b1;
        xfer_row(4'd2, 32'd4, 1'b0, 1'b0);
        c_start = 1'b0;
        xfer_row(4'd5, 32'd8, 1'b0, 1'b1);
        idle_row(1'b0);

        // STMDB {4,14} with writeback.
        issue(16'h4010, 1'b0, 1'b1, 1'b0, 1'b1, 4'd7);
        xfer_row(4'd4,  32'hFFFF_FFF8, 1'b0, 1'b0);
        xfer_row(4'd14, 32'hFFFF_FFFC, 1'b0, 1'b0);
        base_row(4'd7,  32'hFFFF_FFF8);
        idle_row(1'b0);

        // LDMIB {0}, memory not ready for three cycles.
        issue(16'h0001, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        c_ready = 1'b0;
        for (int k = 0; k < 3; k++) xfer_row(4'd0, 32'd4, 1'b0, 1'b0);
        c_ready = 1'b1;
        xfer_row(4'd0, 32'd4, 1'b0, 1'b1);
        idle_row(1'b0);

        // LDMDA {0..15} with writeback: offsets run -60 .. 0.
        issue(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 4'd13);
        for (int k = 0; k < 16; k++)
            xfer_row(4'(k), 32'hFFFF_FFC4 + 32'(4 * k), (k == 15), 1'b0);
        base_row(4'd13, 32'hFFFF_FFC0);
        idle_row(1'b0);

        // Empty list, W=0: done one cycle after start, never leaves IDLE.
        issue(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'd5);
        idle_row(1'b1);
        idle_row(1'b0);

        // Empty list, W=1: a single BASE cycle with zero offset.
        issue(16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2);
        base_row(4'd2, 32'd0);
        idle_row(1'b0);

        // LDMIA {15}: pc_loaded only on the accepted cycle.
        issue(16'h8000, 1'b1, 1'b0, 1'b1, 1'b0, 4'd9);
        c_ready = 1'b0;
        xfer_row(4'd15, 32'd0, 1'b0, 1'b0);
        c_ready = 1'b1;
        xfer_row(4'd15, 32'd0, 1'b1, 1'b1);
        idle_row(1'b0);

        // STMIA {15}: a store of R15 never flags a PC load.
        issue(16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1);
        xfer_row(4'd15, 32'd0, 1'b0, 1'b1);
        idle_row(1'b0);

        for (int r = 0; r < rows.size(); r++) begin
            cur_row = r;
            apply_row(rows[r]);
        end

        // Reset during the 2nd of 4 transfers aborts without done/writeback.
        cur_row = 1000;
        i_rst = 1'b0; i_start = 1'b1; i_reg_list = 16'h000F; i_load = 1'b1;
        i_pre = 1'b0; i_up = 1'b1; i_wb = 1'b1; i_base_code = 4'd6; i_mem_ready = 1'b1;
        #2;
        chk("abort_start_stall", 32'(o_stall), 32'd0);
        step();
        i_start = 1'b0;
        #2;
        chk("abort_x1_code", 32'(o_ldm_reg_code), 32'd0);
        chk("abort_x1_stall", 32'(o_stall), 32'd1);
        step();
        i_rst = 1'b1;
        #2;
        chk("abort_x2_code", 32'(o_ldm_reg_code), 32'd1);
        chk("abort_x2_offset", o_ldm_offset, 32'd4);
        step();
        i_rst = 1'b0;
        #2;
        chk("abort_stall",   32'(o_stall),        32'd0);
        chk("abort_vld",     32'(o_ldm_vld),      32'd0);
        chk("abort_mem_vld", 32'(o_ldm_mem_vld),  32'd0);
        chk("abort_code",    32'(o_ldm_reg_code), 32'd0);
        chk("abort_offset",  o_ldm_offset,        32'd0);
        chk("abort_wb_vld",  32'(o_base_wb_vld),  32'd0);
        chk("abort_done",    32'(o_done),         32'd0);
        step();
        #2;
        chk("abort_done_late", 32'(o_done),        32'd0);
        chk("abort_wb_late",   32'(o_base_wb_vld), 32'd0);
        chk("abort_stall_late", 32'(o_stall),      32'd0);

        // A fresh LDMIA {3} after the abort runs normally.
        i_start = 1'b1; i_reg_list = 16'h0008; i_wb = 1'b0;
        step();
        i_start = 1'b0;
        #2;
        chk("restart_code",    32'(o_ldm_reg_code), 32'd3);
        chk("restart_offset",  o_ldm_offset,        32'd0);
        chk("restart_mem_vld", 32'(o_ldm_mem_vld),  32'd1);
        chk("restart_done",    32'(o_done),         32'd1);
        step();
        #2;
        chk("restart_idle", 32'(o_stall), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
